// File: rtl/regfile_8x_onehot.sv
// Eight-entry register file fed by a one-hot write select, with two registered
// read ports, write-through bypass, a sticky multi-hot error flag and an optional hardwired r0.
module regfile_8x_onehot #(
  parameter int WIDTH   = 8,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       we_sel,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [2:0]       ra,
  input  logic [2:0]       rb,
  output logic [WIDTH-1:0] rd_a,
  output logic [WIDTH-1:0] rd_b,
  output logic             rd_valid,
  output logic             wr_ack,
  output logic             err
);

  logic [WIDTH-1:0] r_mem [8];
  logic [WIDTH-1:0] r_rd_a;
  logic [WIDTH-1:0] r_rd_b;
  logic             r_rd_valid;
  logic             r_wr_ack;
  logic             r_err;

  logic             w_any;
  logic             w_multi;
  logic             w_legal;
  logic [7:0]       w_byp;
  logic [7:0]       w_wr_en;
  logic [WIDTH-1:0] w_val [8];

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign w_any   = |we_sel;
  assign w_multi = |(we_sel & (we_sel - 8'd1));
  assign w_legal = w_any & ~w_multi;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_entry
      localparam bit IS_ZERO_REG = R0_ZERO && (gi == 0);
      assign w_byp[gi]   = w_legal & we_sel[gi];
      assign w_wr_en[gi] = w_byp[gi] & ~IS_ZERO_REG;
      assign w_val[gi]   = IS_ZERO_REG ? '0 : (w_byp[gi] ? wdata : r_mem[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (rst) begin
        r_mem[k] <= '0;
      end else if (w_wr_en[k]) begin
        r_mem[k] <= wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_a     <= '0;
      r_rd_b     <= '0;
      r_rd_valid <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= re;
      r_wr_ack   <= w_legal;
      if (re) begin
        r_rd_a <= w_val[ra];
        r_rd_b <= w_val[rb];
      end
      if (w_multi) begin
        r_err <= 1'b1;
      end
    end
  end

  assign rd_a     = r_rd_a;
  assign rd_b     = r_rd_b;
  assign rd_valid = r_rd_valid;
  assign wr_ack   = r_wr_ack;
  assign err      = r_err;

endmodule

// File: tb/tb_regfile_8x_onehot.sv
// Bench for regfile_8x_onehot: two instances (R0_ZERO=1 and 0) share stimulus and
// are checked every cycle against a behavioural model, plus directed literal checks.
module tb_regfile_8x_onehot;

  logic       clk;
  logic       rst;
  logic [7:0] we_sel;
  logic [7:0] wdata;
  logic       re;
  logic [2:0] ra;
  logic [2:0] rb;

  logic [7:0] d1_rd_a, d1_rd_b, d0_rd_a, d0_rd_b;
  logic       d1_rd_valid, d1_wr_ack, d1_err;
  logic       d0_rd_valid, d0_wr_ack, d0_err;

  int checks   = 0;
  int failures = 0;
  int ack1     = 0;
  int ack0     = 0;
  bit started  = 0;

  // Model state, index 1 = r0 hardwired, index 0 = r0 ordinary.
  logic [7:0] m_r [2][8];
  logic [7:0] e_a [2];
  logic [7:0] e_b [2];
  logic       e_v [2];
  logic       e_ack [2];
  logic       e_err [2];

  regfile_8x_onehot #(.WIDTH(8), .R0_ZERO(1'b1)) dut1 (
    .clk(clk), .rst(rst), .we_sel(we_sel), .wdata(wdata), .re(re), .ra(ra), .rb(rb),
    .rd_a(d1_rd_a), .rd_b(d1_rd_b), .rd_valid(d1_rd_valid), .wr_ack(d1_wr_ack), .err(d1_err)
  );

  regfile_8x_onehot #(.WIDTH(8), .R0_ZERO(1'b0)) dut0 (
    .clk(clk), .rst(rst), .we_sel(we_sel), .wdata(wdata), .re(re), .ra(ra), .rb(rb),
    .rd_a(d0_rd_a), .rd_b(d0_rd_b), .rd_valid(d0_rd_valid), .wr_ack(d0_wr_ack), .err(d0_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mval(input int f, input int k);
    if (f == 1 && k == 0) return 8'h00;
    if ($countones(we_sel) == 1 && we_sel[k]) return wdata;
    return m_r[f][k];
  endfunction

  always @(posedge clk) begin
    for (int f = 0; f < 2; f++) begin
      if (rst) begin
        for (int k = 0; k < 8; k++) m_r[f][k] = 8'h00;
        e_a[f] = 8'h00; e_b[f] = 8'h00;
        e_v[f] = 1'b0; e_ack[f] = 1'b0; e_err[f] = 1'b0;
      end else begin
        int n;
        n = $countones(we_sel);
        if (re) begin
          e_a[f] = mval(f, int'(ra));
          e_b[f] = mval(f, int'(rb));
        end
        e_v[f]   = re;
        e_ack[f] = (n == 1);
        if (n >= 2) e_err[f] = 1'b1;
        if (n == 1) begin
          for (int k = 0; k < 8; k++)
            if (we_sel[k] && !(f == 1 && k == 0)) m_r[f][k] = wdata;
        end
      end
    end
    if (rst) started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("d1_rd_a", d1_rd_a, e_a[1]);
      check("d1_rd_b", d1_rd_b, e_b[1]);
      check("d1_rd_valid", d1_rd_valid, e_v[1]);
      check("d1_wr_ack", d1_wr_ack, e_ack[1]);
      check("d1_err", d1_err, e_err[1]);
      check("d0_rd_a", d0_rd_a, e_a[0]);
      check("d0_rd_b", d0_rd_b, e_b[0]);
      check("d0_rd_valid", d0_rd_valid, e_v[0]);
      check("d0_wr_ack", d0_wr_ack, e_ack[0]);
      check("d0_err", d0_err, e_err[0]);
    end
    if (d1_wr_ack === 1'b1) ack1++;
    if (d0_wr_ack === 1'b1) ack0++;
  end

  task automatic cyc(input logic r, input logic [7:0] ws, input logic [7:0] wd,
                     input logic rr, input logic [2:0] a, input logic [2:0] b);
    @(negedge clk);
    rst = r; we_sel = ws; wdata = wd; re = rr; ra = a; rb = b;
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0);
  endtask

  initial begin
    rst = 1'b1; we_sel = 8'h08; wdata = 8'hFF; re = 1'b0; ra = 3'd0; rb = 3'd0;

    // Reset with a write pending: the write must be dropped.
    cyc(1'b1, 8'h08, 8'hFF, 1'b0, 3'd0, 3'd0);
    cyc(1'b1, 8'h08, 8'hFF, 1'b0, 3'd0, 3'd0);
    ack1 = 0; ack0 = 0;
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 3'd3, 3'd3);
    check("rst_valid_low", d1_rd_valid, 1'b0);
    idle();
    check("rst_rd_a", d1_rd_a, 8'h00);
    check("rst_rd_b", d1_rd_b, 8'h00);
    check("rst_valid", d1_rd_valid, 1'b1);
    check("rst_err", d1_err, 1'b0);
    idle();
    check("rst_no_ack", ack1 + ack0, 0);

    // Write all eight registers, then read pairs (i, 7-i) back-to-back.
    ack1 = 0; ack0 = 0;
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'(1 << i), 8'(8'h10 + i), 1'b0, 3'd0, 3'd0);
    idle();
    idle();
    check("ack_count_r0z", ack1, 8);
    check("ack_count_r0n", ack0, 8);
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) cyc(1'b0, 8'h00, 8'h00, 1'b1, 3'(i), 3'(7 - i));
      else idle();
      if (i > 0) begin
        int j;
        j = i - 1;
        check("wa_r0z_a", d1_rd_a, (j == 0) ? 8'h00 : 8'(8'h10 + j));
        check("wa_r0z_b", d1_rd_b, (j == 7) ? 8'h00 : 8'(8'h17 - j));
        check("wa_r0n_a", d0_rd_a, 8'(8'h10 + j));
        check("wa_valid", d1_rd_valid, 1'b1);
      end
    end

    // Same-cycle write/read bypass on port A only.
    cyc(1'b0, 8'h20, 8'hA5, 1'b1, 3'd5, 3'd4);
    idle();
    check("byp_rd_a", d1_rd_a, 8'hA5);
    check("byp_rd_b", d1_rd_b, 8'h14);

    // Multi-hot select: no write, no bypass, sticky err.
    cyc(1'b0, 8'h18, 8'h77, 1'b1, 3'd3, 3'd4);
    idle();
    check("ill_err", d1_err, 1'b1);
    check("ill_rd_a", d1_rd_a, 8'h13);
    check("ill_rd_b", d1_rd_b, 8'h14);
    check("ill_ack", d1_wr_ack, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 8'h40, 8'($urandom_range(0, 255)), 1'b0, 3'd0, 3'd0);
      check("err_sticky", d1_err, 1'b1);
    end
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 3'd3, 3'd4);
    idle();
    check("ill_r3_kept", d1_rd_a, 8'h13);
    check("ill_r4_kept", d1_rd_b, 8'h14);
    cyc(1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0);
    idle();
    check("err_cleared", d1_err, 1'b0);

    // Hold: re low while r2 keeps changing.
    cyc(1'b0, 8'h04, 8'h22, 1'b0, 3'd0, 3'd0);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 3'd2, 3'd2);
    idle();
    check("hold_pre", d1_rd_a, 8'h22);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'h04, 8'(8'h30 + i), 1'b0, 3'd2, 3'd2);
      check("hold_a", d1_rd_a, 8'h22);
      check("hold_b", d1_rd_b, 8'h22);
    end
    idle();
    check("hold_valid", d1_rd_valid, 1'b0);
    check("hold_a_end", d1_rd_a, 8'h22);

    // Reset mid-stream drops the concurrent write and read.
    cyc(1'b0, 8'h02, 8'h5A, 1'b0, 3'd0, 3'd0);
    cyc(1'b1, 8'h02, 8'h66, 1'b1, 3'd1, 3'd1);
    idle();
    check("mid_valid", d1_rd_valid, 1'b0);
    check("mid_ack", d1_wr_ack, 1'b0);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 3'd1, 3'd1);
    idle();
    check("mid_r1", d0_rd_a, 8'h00);

    // Random traffic, checked by the model each cycle.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] ws;
      int sel, a, b;
      sel = $urandom_range(0, 9);
      if (sel < 3) ws = 8'h00;
      else if (sel < 9) ws = 8'(1 << $urandom_range(0, 7));
      else begin
        a = $urandom_range(0, 7);
        b = (a + 1 + $urandom_range(0, 6)) % 8;
        ws = 8'((1 << a) | (1 << b));
      end
      cyc(($urandom_range(0, 49) == 0), ws, 8'($urandom_range(0, 255)),
          ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_8x_onehot.md
# regfile_8x_onehot

- Eight-entry general-purpose register file for the CPU datapath.
- Consumes the 8-bit one-hot write-select vector produced by the 3-to-8 register-address decoder, together with the writeback data.
- Serves two registered read ports to the operand-fetch stage.
- Enforces one-hot legality on the write select and optionally hardwires r0 to zero.

## Interface
Parameters:
- WIDTH, 8, data width of each register and of all data ports.
- R0_ZERO, 1, when 1 register 0 always reads 0 and writes to it are discarded.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  input  1  system clock; all state updates on rising edge.
  - rst  input  1  synchronous, active-high reset.
- we_sel  input  8  one-hot write select from the decoder; bit i writes register i; all-zero means no write.
- wdata  input  WIDTH  writeback data.
- re  input  1  read request; samples ra/rb this cycle.
- ra  input  3  read address, port A.
- rb  input  3  read address, port B.
- rd_a  output  WIDTH  registered read data, port A.
- rd_b  output  WIDTH  registered read data, port B.
- rd_valid  output  1  pulses high the cycle rd_a/rd_b carry data for a request.
- wr_ack  output  1  pulses high the cycle after a legal write is committed.
- err  output  1  sticky flag: an illegal (multi-hot) we_sel was seen.

## Operation
- Storage: eight WIDTH-bit registers r0..r7.
- Write decode each cycle, from the population count of we_sel:
  - zero bits set: no write; wr_ack=0 next cycle.
  - exactly one bit i set: r[i] <= wdata at the edge; wr_ack=1 next cycle. With R0_ZERO=1 and i=0, r0 is not modified but wr_ack still pulses, because the write is legal.
  - two or more bits set: no register modified; err <= 1; wr_ack=0.
- err is sticky; only rst clears it.
- Read: when re=1, rd_a <= value(ra) and rd_b <= value(rb) at the edge, and rd_valid <= 1. When re=0, rd_a/rd_b hold their previous values and rd_valid <= 0.
- value(k) definition:
  - 0 if R0_ZERO=1 and k=0.
  - otherwise, if a legal write targets k in the same cycle: wdata (write-through bypass).
  - otherwise r[k].
- The bypass applies independently to both ports; ra=rb is allowed and both ports return the same value.
- An illegal write never bypasses.

## Timing
- Reset, when rst=1 at an edge:
  - r0..r7 = 0; rd_a = rd_b = 0; rd_valid = 0; wr_ack = 0; err = 0.
  - rst overrides any simultaneous write or read in that cycle.
- Reset mid-operation: a write or read presented in the same cycle as rst is dropped entirely; no wr_ack or rd_valid follows it.
- Write latency: data presented in cycle N is visible to a plain (non-bypass) read issued in cycle N+1.
- Read latency: request in cycle N, data and rd_valid in cycle N+1.
- Same-cycle write and read to the same index: the read returns the new data in N+1.
- Back-to-back reads (re held high) give one result per cycle. rd_valid stays high continuously.
- No backpressure: the consumer must take rd_a/rd_b in the rd_valid cycle.
- No combinational path from any input to any output; all outputs are flops.

## Test plan
- Reset: drive rst=1 for 2 cycles with we_sel=8'h08, wdata=8'hFF. Then read ra=3, rb=3 -> rd_a = rd_b = 8'h00, rd_valid=1 one cycle after re, err=0, no wr_ack seen.
- Write/read all: write r_i = 8'h10+i using we_sel = 1<<i for i=0..7, then read every pair (i, 7-i).
  - R0_ZERO=1: r0 reads 8'h00, others read 8'h10+i; wr_ack pulses 8 times.
  - R0_ZERO=0: r0 reads 8'h10.
- Bypass: cycle N write we_sel=8'h20, wdata=8'hA5 with re=1, ra=5, rb=4 -> cycle N+1 rd_a=8'hA5, rd_b = old r4.
- Illegal select: we_sel=8'h18, wdata=8'h77 with re=1, ra=3, rb=4.
  - Response: err=1 from the next cycle onward; r3 and r4 unchanged; rd_a/rd_b return the old values; wr_ack=0.
  - err stays 1 through 10 legal writes, then clears only after rst.
- Hold: re=0 for 5 cycles while writing r2 -> rd_a/rd_b unchanged and rd_valid=0 throughout.
- Reset mid-stream: re=1 and we_sel=8'h02 asserted in the same cycle as rst -> next cycle rd_valid=0, wr_ack=0, r1 reads 8'h00 afterwards.
